multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle control FSM for the 32-bit ARM-subset datapath: sequences fetch, decode, execute, memory and writeback.
//  It shares one unified instruction/data memory port via a req/ready handshake, evaluates condition codes
//  against an internal NZCV register and drives all datapath mux/enable selects. Sits beside the datapath and
//  replaces the single-cycle decoder.
// PARAMETERS
//  FLAGS_RST  4'b0000  reset value of NZCV flag register {N,Z,C,V}
//  WAIT_MAX   8'd0     max mem_ready wait cycles before bus_err; 0 = wait forever
// PORTS
//  clk          in   1  clock, rising edge
//  reset        in   1  async, active-high
//  cond         in   4  instr[31:28] from IR
//  op           in   2  instr[27:26]
//  funct        in   6  instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (op=00) / L (op=01)
//  rd           in   4  instr[15:12]
//  alu_flags    in   4  live ALU {N,Z,C,V}
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_req      out  1  memory access request, held until mem_ready
//  mem_we       out  1  write strobe, valid while mem_req
//  adr_src      out  1  0=PC, 1=ALU result register as memory address
//  ir_write     out  1  latch read data into IR
//  pc_write     out  1  load PC from result bus
//  reg_write    out  1  register file write enable
//  alu_src_a    out  2  00=rd1, 01=PC, 10=ALUOut
//  alu_src_b    out  2  00=shifted rd2, 01=ext_imm, 10=const 4
//  result_src   out  2  00=ALUOut reg, 01=mem data reg, 10=ALU output direct
//  alu_control  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
//  imm_src      out  2  00=imm8, 01=imm12, 10=branch imm24<<2 sign-ext
//  reg_src      out  2  [0]: ra1=R15, [1]: ra2=Rd
//  flags_q      out  4  architectural NZCV
//  bus_err      out  1  1-cycle pulse: undefined op or memory timeout
//  state_q      out  4  current state (debug)
// BEHAVIOUR
//  Reset: state=FETCH, flags_q=FLAGS_RST; wait counter=0. All enables and bus_err=0 while reset is high.
//   Selects are 0 during reset except FETCH defaults.
//  Outputs are Moore (decoded from state_q) except ir_write and pc_write in FETCH and mem_req deassertion,
//   which are qualified by mem_ready.
//  FETCH: mem_req=1, adr_src=0, a=01, b=10, ADD, result_src=10. When mem_ready=1: ir_write=1, pc_write=1
//   (PC+=4), go to DECODE. Otherwise stay in FETCH.
//  DECODE: a=01, b=10 (ALUOut=PC+8), reg_src from op. Evaluate cond vs flags_q:
//   EQ..LE per ARM, AL=1110 true, 1111 false.
//   Fail -> FETCH (no side effects). op=11 -> bus_err pulse, FETCH.
//   op=00 -> EXECR/EXECI by funct[5]. op=01 -> MEMADR. op=10 -> BRANCH.
//  EXECR/EXECI: a=00, b=00/01, imm_src=00, ALU op from cmd: 0100 ADD, 0010 SUB, 1010 CMP(SUB),
//   0000 AND, 1100 ORR; other cmd -> bus_err, FETCH.
//   If S=1 or CMP: flags_q<=alu_flags at end of cycle. ADD/SUB/CMP update all four flags; AND/ORR update N,Z only.
//   Next: CMP -> FETCH, else ALUWB.
//  ALUWB: result_src=00, reg_write=1, pc_write=(rd==15). -> FETCH.
//  MEMADR: a=00, b=01, imm_src=01, ADD (offset up). -> MEMRD if L=1, else MEMWR.
//  MEMRD: mem_req=1, adr_src=1, mem_we=0. On mem_ready -> MEMWB.
//  MEMWR: mem_req=1, adr_src=1, mem_we=1, ra2=Rd. On mem_ready -> FETCH.
//  MEMWB: result_src=01, reg_write=1, pc_write=(rd==15). -> FETCH.
//  BRANCH: a=10, b=01, imm_src=10, ADD, result_src=10, pc_write=1. -> FETCH.
//  Wait counter counts cycles in a req state with mem_ready=0. If WAIT_MAX!=0 and count reaches WAIT_MAX:
//   drop req, pulse bus_err, go to FETCH; PC is not advanced.
//  Latency (zero wait): DP 4 cycles, CMP 3, LDR 5, STR 4, BRANCH 3, cond-fail 2.
//   Each extra mem_ready=0 cycle adds 1.
//  Async reset mid-access drops mem_req immediately; nothing is written.
// TESTING
//  reset, mem_ready=1, IR=E0810002 (ADD R0,R1,R2) -> states F,D,ER,AW; reg_write=1 in cycle 4 only.
//  flags_q=0100, IR=0A000002 (BEQ +8) -> BRANCH, pc_write=1 imm_src=10;
//   flags_q=0000 same IR -> D->F, no pc_write.
//  IR=E5910004 (LDR R1,[R1,#4]), mem_ready low 3 cycles in MEMRD -> mem_req held 4 cycles, MEMWB after.
//  IR=E3500000 (CMP R0,#0), alu_flags=0110 -> flags_q=0110 after EXECI, no reg_write, back to FETCH.
//  WAIT_MAX=4, mem_ready=0 in FETCH -> bus_err pulse on 4th wait cycle, ir_write/pc_write never asserted.
//  Assert reset during MEMWR with mem_req=1 -> mem_req=0 same cycle, state_q=FETCH, flags_q=FLAGS_RST.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the ARM-subset datapath. Sequences fetch, decode,
// execute, memory and writeback over one shared memory port, owns the NZCV
// register and drives every datapath select and enable.
//
// Memory handshake: mem_req is held high for the whole access and the access
// completes on the first rising edge where mem_req and mem_ready are both 1.
// mem_we is only meaningful while mem_req is high. When WAIT_MAX is non-zero
// and the access has waited WAIT_MAX cycles, mem_req drops in that cycle,
// bus_err pulses and the FSM restarts at FETCH without advancing the PC.
`timescale 1ns/1ps
module multicycle_ctrl #(
    parameter logic [3:0] FLAGS_RST = 4'b0000,
    parameter logic [7:0] WAIT_MAX  = 8'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_control,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [3:0] flags_q,
    output logic       bus_err,
    output logic [3:0] state_q
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXECR  = 4'd2,
        S_EXECI  = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWR  = 4'd7,
        S_MEMWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic [3:0] flags_next;
    logic       cond_ok, req_state, timeout;
    logic       cmd_valid, cmd_cmp, cmd_logic;
    logic [1:0] cmd_alu;
    // Enables before reset gating; reset forces every enable low at once.
    logic       mem_req_i, mem_we_i, ir_write_i, pc_write_i, reg_write_i, bus_err_i;

    // Condition-code check of the instruction against the architectural flags.
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'b0000: cond_ok = flags_q[2];
            4'b0001: cond_ok = !flags_q[2];
            4'b0010: cond_ok = flags_q[1];
            4'b0011: cond_ok = !flags_q[1];
            4'b0100: cond_ok = flags_q[3];
            4'b0101: cond_ok = !flags_q[3];
            4'b0110: cond_ok = flags_q[0];
            4'b0111: cond_ok = !flags_q[0];
            4'b1000: cond_ok = flags_q[1] && !flags_q[2];
            4'b1001: cond_ok = !flags_q[1] || flags_q[2];
            4'b1010: cond_ok = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ok = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ok = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: cond_ok = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // Data-processing command decode: ALU op, compare-only and logical-class flags.
    always_comb begin
        cmd_valid = 1'b1;
        cmd_cmp   = 1'b0;
        cmd_logic = 1'b0;
        cmd_alu   = 2'b00;
        case (funct[4:1])
            4'b0100: cmd_alu = 2'b00;
            4'b0010: cmd_alu = 2'b01;
            4'b1010: begin cmd_alu = 2'b01; cmd_cmp = 1'b1; end
            4'b0000: begin cmd_alu = 2'b10; cmd_logic = 1'b1; end
            4'b1100: begin cmd_alu = 2'b11; cmd_logic = 1'b1; end
            default: cmd_valid = 1'b0;
        endcase
    end

    assign req_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout   = req_state && !mem_ready && (WAIT_MAX != 8'd0) &&
                       (wait_cnt == WAIT_MAX - 8'd1);

    // Wait counter: counts stalled cycles of the current access, cleared on completion or timeout.
    always_comb begin
        wait_cnt_next = 8'd0;
        if (req_state && !mem_ready && !timeout)
            wait_cnt_next = wait_cnt + 8'd1;
    end

    // Next-state, flag update and datapath control decode.
    always_comb begin
        state_next  = state;
        flags_next  = flags_q;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        ir_write_i  = 1'b0;
        pc_write_i  = 1'b0;
        reg_write_i = 1'b0;
        bus_err_i   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = 2'b00;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req_i  = !timeout;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write_i = 1'b1;
                    pc_write_i = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    bus_err_i  = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                reg_src   = {(op == 2'b01) && !funct[0], op == 2'b10};
                if (!cond_ok) begin
                    state_next = S_FETCH;
                end else begin
                    case (op)
                        2'b00:   state_next = funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   state_next = S_MEMADR;
                        2'b10:   state_next = S_BRANCH;
                        default: begin bus_err_i = 1'b1; state_next = S_FETCH; end
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                alu_src_b = (state == S_EXECI) ? 2'b01 : 2'b00;
                if (!cmd_valid) begin
                    bus_err_i  = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    alu_control = cmd_alu;
                    if (funct[0] || cmd_cmp)
                        flags_next = cmd_logic ? {alu_flags[3:2], flags_q[1:0]} : alu_flags;
                    state_next = cmd_cmp ? S_FETCH : S_ALUWB;
                end
            end
            S_ALUWB: begin
                reg_write_i = 1'b1;
                pc_write_i  = (rd == 4'd15);
                state_next  = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_b  = 2'b01;
                imm_src    = 2'b01;
                reg_src    = {!funct[0], 1'b0};
                state_next = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_i = !timeout;
                adr_src   = 1'b1;
                if (mem_ready)    state_next = S_MEMWB;
                else if (timeout) begin bus_err_i = 1'b1; state_next = S_FETCH; end
            end
            S_MEMWR: begin
                mem_req_i = !timeout;
                mem_we_i  = !timeout;
                adr_src   = 1'b1;
                reg_src   = 2'b10;
                if (mem_ready)    state_next = S_FETCH;
                else if (timeout) begin bus_err_i = 1'b1; state_next = S_FETCH; end
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_i = 1'b1;
                pc_write_i  = (rd == 4'd15);
                state_next  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_write_i = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // State, flags and wait counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            flags_q  <= FLAGS_RST;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_next;
            flags_q  <= flags_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    assign mem_req   = mem_req_i   && !reset;
    assign mem_we    = mem_we_i    && !reset;
    assign ir_write  = ir_write_i  && !reset;
    assign pc_write  = pc_write_i  && !reset;
    assign reg_write = reg_write_i && !reset;
    assign bus_err   = bus_err_i   && !reset;
    assign state_q   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction scenarios followed by random
// instruction streams, each checked cycle by cycle against an instruction-level
// model of the controller's observable behaviour.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam logic [3:0] FLAGS_RST = 4'b1010;
  localparam logic [7:0] WAIT_MAX  = 8'd4;

  localparam logic [3:0] F  = 4'd0, D  = 4'd1, ER = 4'd2, EI = 4'd3, AW = 4'd4;
  localparam logic [3:0] MA = 4'd5, MR = 4'd6, MWR = 4'd7, MWB = 4'd8, BR = 4'd9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] cond, rd, alu_flags;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;

  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, bus_err;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_control, imm_src, reg_src;
  logic [3:0] flags_q, state_q;

  logic       mem_req_z, mem_we_z, adr_src_z, ir_write_z, pc_write_z, reg_write_z, bus_err_z;
  logic [1:0] alu_src_a_z, alu_src_b_z, result_src_z, alu_control_z, imm_src_z, reg_src_z;
  logic [3:0] flags_q_z, state_q_z;

  multicycle_ctrl #(.FLAGS_RST(FLAGS_RST), .WAIT_MAX(WAIT_MAX)) u_dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_control(alu_control), .imm_src(imm_src), .reg_src(reg_src),
    .flags_q(flags_q), .bus_err(bus_err), .state_q(state_q)
  );

  // Second instance with no wait limit: must stall indefinitely.
  multicycle_ctrl #(.FLAGS_RST(FLAGS_RST), .WAIT_MAX(8'd0)) u_dut_nolimit (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .mem_ready(mem_ready), .mem_req(mem_req_z), .mem_we(mem_we_z),
    .adr_src(adr_src_z), .ir_write(ir_write_z), .pc_write(pc_write_z), .reg_write(reg_write_z),
    .alu_src_a(alu_src_a_z), .alu_src_b(alu_src_b_z), .result_src(result_src_z),
    .alu_control(alu_control_z), .imm_src(imm_src_z), .reg_src(reg_src_z),
    .flags_q(flags_q_z), .bus_err(bus_err_z), .state_q(state_q_z)
  );

  // Observed per-cycle vector: state, enables {req,we,adr,irw,pcw,rw,berr}, alu_control, imm_src.
  logic [14:0] obs_vec;
  assign obs_vec = {state_q, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, bus_err,
                    alu_control, imm_src};

  // ---------------- scoreboard ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  model_flags;
  logic [14:0] exp_q[$];
  logic        rdy_q[$];

  function automatic logic [14:0] mk(input logic [3:0] st, input logic [6:0] en,
                                     input logic [1:0] aluc, input logic [1:0] imm);
    return {st, en, aluc, imm};
  endfunction

  // ARM condition: base test chosen by cond[3:1], inverted when cond[0] is set.
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic rdy, input logic [14:0] exp, input string tag);
    mem_ready = rdy;
    @(negedge clk);
    check(tag, 32'(obs_vec), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic run_queue(input string tag);
    logic r;
    logic [14:0] e;
    while (exp_q.size() > 0) begin
      r = rdy_q.pop_front();
      e = exp_q.pop_front();
      step(r, e, tag);
    end
  endtask

  task automatic push(input logic r, input logic [14:0] e);
    rdy_q.push_back(r);
    exp_q.push_back(e);
  endtask

  // Builds the expected cycle trace of one instruction from its fields, runs it, checks flags.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn,
                           input logic [3:0] r, input logic [3:0] af,
                           input int sf, input int sm, input string tag);
    logic pass, valid, is_cmp, is_logic, rd15;
    logic [1:0] aluc;
    cond = c; op = o; funct = fn; rd = r; alu_flags = af;
    pass = cond_true(c, model_flags);
    rd15 = (r == 4'hF);
    for (int i = 0; i < sf; i++) push(1'b0, mk(F, 7'b1000000, 2'b00, 2'b00));
    push(1'b1, mk(F, 7'b1001100, 2'b00, 2'b00));
    push(1'b0, mk(D, {6'b0, pass && (o == 2'b11)}, 2'b00, 2'b00));
    if (pass) begin
      case (o)
        2'b00: begin
          valid = 1'b1; is_cmp = 1'b0; is_logic = 1'b0; aluc = 2'b00;
          case (fn[4:1])
            4'b0100: aluc = 2'b00;
            4'b0010: aluc = 2'b01;
            4'b1010: begin aluc = 2'b01; is_cmp = 1'b1; end
            4'b0000: begin aluc = 2'b10; is_logic = 1'b1; end
            4'b1100: begin aluc = 2'b11; is_logic = 1'b1; end
            default: begin valid = 1'b0; end
          endcase
          push(1'b0, mk(fn[5] ? EI : ER, {6'b0, !valid}, valid ? aluc : 2'b00, 2'b00));
          if (valid && (fn[0] || is_cmp))
            model_flags = is_logic ? {af[3:2], model_flags[1:0]} : af;
          if (valid && !is_cmp) push(1'b0, mk(AW, {4'b0, rd15, 1'b1, 1'b0}, 2'b00, 2'b00));
        end
        2'b01: begin
          push(1'b0, mk(MA, 7'b0, 2'b00, 2'b01));
          if (fn[0]) begin
            for (int i = 0; i < sm; i++) push(1'b0, mk(MR, 7'b1010000, 2'b00, 2'b00));
            push(1'b1, mk(MR, 7'b1010000, 2'b00, 2'b00));
            push(1'b0, mk(MWB, {4'b0, rd15, 1'b1, 1'b0}, 2'b00, 2'b00));
          end else begin
            for (int i = 0; i < sm; i++) push(1'b0, mk(MWR, 7'b1110000, 2'b00, 2'b00));
            push(1'b1, mk(MWR, 7'b1110000, 2'b00, 2'b00));
          end
        end
        2'b10: push(1'b0, mk(BR, 7'b0000100, 2'b00, 2'b10));
        default: ;
      endcase
    end
    run_queue(tag);
    check({tag, "_flags"}, 32'(flags_q), 32'(model_flags));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: no summary after 1ms, required end of stimulus");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] rc;
    logic [5:0] rf;
    logic [3:0] cmds [5];
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b1010; cmds[3] = 4'b0000; cmds[4] = 4'b1100;

    reset = 1'b1; cond = 4'h0; op = 2'b00; funct = 6'h0; rd = 4'h0; alu_flags = 4'h0;
    mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;

    // Reset state: FETCH, flags at reset value, every enable low even with mem_ready high.
    @(negedge clk);
    check("rst_state", 32'(state_q), 32'(F));
    check("rst_flags", 32'(flags_q), 32'(FLAGS_RST));
    check("rst_enables", 32'({mem_req, mem_we, ir_write, pc_write, reg_write, bus_err}), 32'(0));
    check("rst_selects", 32'({adr_src, alu_src_a, alu_src_b, result_src}), 32'(7'b0011010));
    @(posedge clk); #1;
    reset = 1'b0;
    model_flags = FLAGS_RST;

    // ADD R0,R1,R2 (E0810002): F, D, ER, AW with reg_write only in AW.
    run_instr(4'hE, 2'b00, 6'b001000, 4'h0, 4'b1111, 0, 0, "add_r");
    // CMP R0,#0 (E3500000), alu_flags 0110: flags take 0110, no writeback.
    run_instr(4'hE, 2'b00, 6'b110101, 4'h0, 4'b0110, 0, 0, "cmp_0110");
    // BEQ (0A000002) with Z set: branch taken.
    run_instr(4'hE, 2'b00, 6'b110101, 4'h0, 4'b0100, 0, 0, "cmp_0100");
    run_instr(4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000, 0, 0, "beq_taken");
    // BEQ with Z clear: decode straight back to fetch.
    run_instr(4'hE, 2'b00, 6'b110101, 4'h0, 4'b0000, 0, 0, "cmp_0000");
    run_instr(4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000, 0, 0, "beq_not");
    // LDR R1,[R1,#4] (E5910004) with 3 stall cycles in MEMRD.
    run_instr(4'hE, 2'b01, 6'b011001, 4'h1, 4'b0000, 0, 3, "ldr_stall");
    // STR with a stall, and ADDS to PC, and an undefined op.
    run_instr(4'hE, 2'b01, 6'b011000, 4'h2, 4'b0000, 1, 1, "str_stall");
    run_instr(4'hE, 2'b00, 6'b101001, 4'hF, 4'b1001, 0, 0, "adds_pc");
    run_instr(4'hE, 2'b11, 6'b000000, 4'h0, 4'b0000, 0, 0, "undef_op");
    run_instr(4'hE, 2'b00, 6'b000111, 4'h3, 4'b0000, 0, 0, "undef_cmd");

    // Fetch timeout: bus_err on every 4th stalled cycle, no ir/pc write; no-limit copy waits.
    cond = 4'hE; op = 2'b00; funct = 6'b001000; rd = 4'h0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      check("fetch_tmo", 32'(obs_vec),
            32'(((i % 4) == 3) ? mk(F, 7'b0000001, 2'b00, 2'b00) : mk(F, 7'b1000000, 2'b00, 2'b00)));
      check("nolimit_wait", 32'({state_q_z, mem_req_z, bus_err_z, ir_write_z}), 32'({F, 3'b100}));
      @(posedge clk); #1;
    end
    run_instr(4'hE, 2'b00, 6'b001000, 4'h5, 4'b0000, 0, 0, "after_tmo");

    // Random instruction stream.
    for (int n = 0; n < 60; n++) begin
      rc = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
      rf = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 4) != 0) rf[4:1] = cmds[$urandom_range(0, 4)];
      run_instr(rc, 2'($urandom_range(0, 3)), rf, 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), "rand");
    end

    // Reset during a stalled store: mem_req drops at once, FSM and flags return to reset values.
    run_instr(4'hE, 2'b00, 6'b110101, 4'h0, 4'b0011, 0, 0, "cmp_0011");
    cond = 4'hE; op = 2'b01; funct = 6'b011000; rd = 4'h4;
    step(1'b1, mk(F, 7'b1001100, 2'b00, 2'b00), "str_rst_f");
    step(1'b0, mk(D, 7'b0, 2'b00, 2'b00), "str_rst_d");
    step(1'b0, mk(MA, 7'b0, 2'b00, 2'b01), "str_rst_ma");
    mem_ready = 1'b0;
    @(negedge clk);
    check("str_rst_pre", 32'({state_q, mem_req, mem_we}), 32'({MWR, 2'b11}));
    #1 reset = 1'b1;
    #1;
    check("str_rst_req", 32'({mem_req, mem_we, reg_write, bus_err}), 32'(0));
    check("str_rst_state", 32'(state_q), 32'(F));
    check("str_rst_flags", 32'(flags_q), 32'(FLAGS_RST));
    @(posedge clk); #1;
    reset = 1'b0;
    model_flags = FLAGS_RST;
    run_instr(4'hE, 2'b00, 6'b001000, 4'h0, 4'b0000, 0, 0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
